uart_prog_loader: RTL

Parametrised successor to the fixed 4-byte UART instruction loader in the smart-switch wrapper. It sits between the UART receiver and instruction memory. It packs received bytes LSB-first into DATA_W-bit words and writes them to sequential memory addresses, then flags completion. Beyond the old loader, it adds configurable word width, program length, an inter-byte timeout, early termination on UART BREAK, and restart control.

---
 rtl/uart_prog_loader.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// UART byte stream to instruction memory loader; packs bytes LSB-first into DATA_W-bit words.
// Optional macro CHECKSUM_EN adds a trailing XOR checksum byte verified in a CHECK state.
module uart_prog_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_WORDS   = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              write_done,
  output logic              err_timeout,
  output logic              err_chksum
);
  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned BIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSEMBLE,
    ST_WRITE,
`ifdef CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d, lane;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d, next_count, base_count;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                write_done_q, write_done_d;
  logic                err_timeout_q, err_timeout_d;
  logic                brk_pend_q, brk_pend_d;
  logic                take_byte, last_lane, tmo_hit;
`ifdef CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
  logic                err_chksum_q, err_chksum_d;

  function automatic logic [7:0] fold(input logic [DATA_W-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < LANES; i++) x ^= w[i*8 +: 8];
    return x;
  endfunction
`endif

  assign last_lane = (byte_idx_q == BIDX_W'(LANES - 1));
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign next_count = word_count_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shift_d       = shift_q;
    tmo_d         = tmo_q;
    word_count_d  = word_count_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    write_done_d  = write_done_q;
    err_timeout_d = err_timeout_q;
    brk_pend_d    = brk_pend_q;
    take_byte     = 1'b0;
    base_count    = word_count_q;
    lane          = '0;
`ifdef CHECKSUM_EN
    chk_d         = chk_q;
    err_chksum_d  = err_chksum_q;
`endif
    case (state_q)
      ST_IDLE: if (load_en) begin
        state_d       = ST_ASSEMBLE;
        word_count_d  = '0;
        byte_idx_d    = '0;
        tmo_d         = '0;
        err_timeout_d = 1'b0;
        brk_pend_d    = 1'b0;
`ifdef CHECKSUM_EN
        chk_d         = '0;
        err_chksum_d  = 1'b0;
`endif
      end
      ST_ASSEMBLE: begin
        if (!load_en) begin
          state_d    = ST_IDLE;
          byte_idx_d = '0;
          tmo_d      = '0;
        end else if (rx_break && !(rx_valid && last_lane)) begin
          state_d      = ST_DONE;
          write_done_d = 1'b1;
          byte_idx_d   = '0;
          tmo_d        = '0;
        end else if (rx_valid) begin
          take_byte  = 1'b1;
          brk_pend_d = rx_break;
        end else if (byte_idx_q != '0) begin
          if (tmo_hit) begin
            byte_idx_d    = '0;
            tmo_d         = '0;
            err_timeout_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      ST_WRITE: begin
        word_count_d = next_count;
        byte_idx_d   = '0;
        tmo_d        = '0;
        brk_pend_d   = 1'b0;
`ifdef CHECKSUM_EN
        chk_d        = chk_q ^ fold(mem_wdata_q);
`endif
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (next_count == CNT_W'(NUM_WORDS)) begin
`ifdef CHECKSUM_EN
          // a byte arriving alongside the final write is the checksum itself
          if (rx_valid) begin
            err_chksum_d = (rx_data != chk_d);
            state_d      = ST_DONE;
            write_done_d = 1'b1;
          end else if (brk_pend_q || rx_break) begin
            err_chksum_d = 1'b1;
            state_d      = ST_DONE;
            write_done_d = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
`else
          state_d      = ST_DONE;
          write_done_d = 1'b1;
`endif
        end else if (brk_pend_q || rx_break) begin
          state_d      = ST_DONE;
          write_done_d = 1'b1;
        end else begin
          state_d = ST_ASSEMBLE;
          if (rx_valid) begin
            take_byte  = 1'b1;
            base_count = next_count;
          end
        end
      end
`ifdef CHECKSUM_EN
      ST_CHECK: begin
        if (!load_en) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (rx_valid) begin
          err_chksum_d = (rx_data != chk_q);
          state_d      = ST_DONE;
          write_done_d = 1'b1;
        end else if (rx_break || tmo_hit) begin
          err_chksum_d = 1'b1;
          state_d      = ST_DONE;
          write_done_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
      ST_DONE: if (!load_en) begin
        state_d      = ST_IDLE;
        write_done_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // lane fill shared by ASSEMBLE and the byte that overlaps a WRITE
    if (take_byte) begin
      lane = byte_idx_d;
      shift_d[{lane, 3'b000} +: 8] = rx_data;
      tmo_d = '0;
      if (lane == BIDX_W'(LANES - 1)) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = base_count[ADDR_W-1:0];
        mem_wdata_d = shift_d;
        state_d     = ST_WRITE;
        byte_idx_d  = '0;
      end else begin
        byte_idx_d = lane + BIDX_W'(1);
      end
    end

    busy_d = (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE)
`ifdef CHECKSUM_EN
             || (state_d == ST_CHECK)
`endif
             ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= '0;
      shift_q       <= '0;
      tmo_q         <= '0;
      word_count_q  <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      write_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      brk_pend_q    <= 1'b0;
`ifdef CHECKSUM_EN
      chk_q         <= '0;
      err_chksum_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      shift_q       <= shift_d;
      tmo_q         <= tmo_d;
      word_count_q  <= word_count_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      write_done_q  <= write_done_d;
      err_timeout_q <= err_timeout_d;
      brk_pend_q    <= brk_pend_d;
`ifdef CHECKSUM_EN
      chk_q         <= chk_d;
      err_chksum_q  <= err_chksum_d;
`endif
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign word_count  = word_count_q;
  assign busy        = busy_q;
  assign write_done  = write_done_q;
  assign err_timeout = err_timeout_q;
`ifdef CHECKSUM_EN
  assign err_chksum  = err_chksum_q;
`else
  assign err_chksum  = 1'b0;
`endif
endmodule
